// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns mnemonic-level fields into 32-bit MIPS words and streams them to IMEM.
// Latency: an accepted word appears on wr_data one cycle after acceptance at the earliest; there is no bypass.
// Backpressure: wr_ready low holds wr_addr/wr_data and fills the FIFO. in_ready drops when the FIFO is full.
// Optional feature macro: BRANCH_TARGET_CALC_EN (absolute beq/j/jal targets, with an accept counter pc).
module mips_instr_encoder #(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 4,   // power of 2, >= 2
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int                PW   = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    // Mnemonic op codes on in_op
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_JR   = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SLTI = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_J    = 4'd11;
    localparam logic [3:0] OP_JAL  = 4'd12;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OP    = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PW:0]         wptr_q, rptr_q;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                err_q;
    logic [1:0]          err_code_q;

    logic                fifo_empty, fifo_full;
    logic                accept, push, pop;
    logic [31:0]         enc_word;
    logic [1:0]          enc_code;
    logic                imm_fits;

`ifdef BRANCH_TARGET_CALC_EN
    logic [ADDR_W-1:0]   pc_q;
    logic [26:0]         br_diff;
    logic                br_fits;

    // Branch offset relative to the following instruction; 27 bits hold any target minus pc+1
    assign br_diff = {1'b0, in_imm} - {{(27-ADDR_W){1'b0}}, pc_q} - 27'd1;
    assign br_fits = (&br_diff[26:15]) | ~(|br_diff[26:15]);
`endif

    // I-type immediates must be a sign-extended 16-bit value
    assign imm_fits = (in_imm[25:16] == {10{in_imm[15]}});

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

    assign accept = in_valid & in_ready;
    assign push   = accept & (enc_code == ERR_NONE);
    assign pop    = wr_valid & wr_ready;

    // Field encoder: builds the word and flags illegal ops / out-of-range immediates
    always_comb begin
        enc_word = 32'h0;
        enc_code = ERR_NONE;
        case (in_op)
            OP_ADD:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
            OP_SUB:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
            OP_SLT:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
            OP_AND:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h24};
            OP_OR:   enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h25};
            OP_JR:   enc_word = {6'h00, in_rs, 5'h00, 5'h00, 5'h00, 6'h08};
            OP_ADDI: begin
                enc_word = {6'h08, in_rs, in_rt, in_imm[15:0]};
                if (!imm_fits) enc_code = ERR_RANGE;
            end
            OP_SLTI: begin
                enc_word = {6'h0A, in_rs, in_rt, in_imm[15:0]};
                if (!imm_fits) enc_code = ERR_RANGE;
            end
            OP_LW: begin
                enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
                if (!imm_fits) enc_code = ERR_RANGE;
            end
            OP_SW: begin
                enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
                if (!imm_fits) enc_code = ERR_RANGE;
            end
            OP_BEQ: begin
`ifdef BRANCH_TARGET_CALC_EN
                enc_word = {6'h04, in_rs, in_rt, br_diff[15:0]};
                if (!br_fits) enc_code = ERR_RANGE;
`else
                enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
                if (!imm_fits) enc_code = ERR_RANGE;
`endif
            end
            OP_J:    enc_word = {6'h02, in_imm};
            OP_JAL:  enc_word = {6'h03, in_imm};
            default: enc_code = ERR_OP;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: an errored accept drains what is already buffered, without done
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (accept) begin
                    if (enc_code != ERR_NONE) state_d = S_DRAIN;
                    else if (in_last)         state_d = S_FLUSH;
                end
            end
            S_FLUSH: if (fifo_empty) state_d = S_IDLE;
            S_DRAIN: if (fifo_empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and registered FIFO pointers only (no same-cycle pop->push path)
    always_comb begin
        in_ready = (state_q == S_RUN) && !fifo_full;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_FLUSH) && fifo_empty;
        wr_valid = !fifo_empty;
        wr_data  = fifo_empty ? 32'h0 : mem_q[rptr_q[PW-1:0]];
        wr_addr  = wr_addr_q;
        err      = err_q;
        err_code = err_code_q;
    end

    // FIFO pointers; reset discards any buffered words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (PW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (PW+1)'(1);
        end
    end

    // FIFO storage; contents are only observable through valid pointers, so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= enc_word;
    end

    // Write address and sticky error; a start from IDLE rearms both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q  <= BASE;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if ((state_q == S_IDLE) && start) begin
            wr_addr_q  <= BASE;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (pop) wr_addr_q <= wr_addr_q + ADDR_W'(1);
            if (accept && (enc_code != ERR_NONE)) begin
                err_q      <= 1'b1;
                err_code_q <= enc_code;
            end
        end
    end

`ifdef BRANCH_TARGET_CALC_EN
    // Address of the instruction currently offered: counts accepts since start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               pc_q <= BASE;
        else if ((state_q == S_IDLE) && start) pc_q <= BASE;
        else if (accept)                       pc_q <= pc_q + ADDR_W'(1);
    end
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [25:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, done, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rdy_mode = 2;          // 0 random, 1 forced low, 2 forced high

    logic [9:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    longint funct_tab[6] = '{32, 34, 42, 36, 37, 8};
    longint opc_tab[7]   = '{8, 10, 35, 43, 4, 2, 3};

    mips_instr_encoder dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_last(in_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: instruction semantics from the field tables, with range checks on the signed value
    function automatic void model(input int op, input longint rs, input longint rt, input longint rd,
                                  input logic [25:0] imm, input int pc,
                                  output logic [31:0] w, output int code);
        longint v;
        longint acc;
        code = 0;
        acc  = 0;
        if (op > 12) begin
            code = 1;
        end else if (op == 5) begin
            acc = rs * (1 << 21) + funct_tab[op];
        end else if (op < 5) begin
            acc = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + funct_tab[op];
        end else if (op >= 11) begin
            acc = opc_tab[op-6] * (longint'(1) << 26) + longint'(imm);
        end else begin
            v = longint'(imm);
            if (v >= (1 << 25)) v = v - (1 << 26);
`ifdef BRANCH_TARGET_CALC_EN
            if (op == 10) v = longint'(imm) - (pc + 1);
`endif
            if (v < -32768 || v > 32767) code = 2;
            else acc = opc_tab[op-6] * (longint'(1) << 26) + rs * (1 << 21) + rt * (1 << 16) + (v & 'hFFFF);
        end
        w = acc[31:0];
    endfunction

    // Write-port driver
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       wr_ready = ($urandom_range(0, 3) != 0);
            1:       wr_ready = 1'b0;
            default: wr_ready = 1'b1;
        endcase
    end

    // Monitor: every IMEM transfer is popped against the scoreboard; done cycles are counted
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
            end else begin
                chk("wr_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
                chk("wr_data", wr_data, exp_data_q.pop_front());
            end
        end
        if (!rst && done) done_cnt++;
    end

    task automatic do_start();
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [25:0] imm, input logic last,
                         input int limit, output bit acc);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < limit && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle_and_check(input int exp_done, input int exp_err, input int exp_code);
        bit idle = 1'b0;
        for (int c = 0; c < 400 && !idle; c++) begin
            @(negedge clk);
            idle = !busy;
        end
        chk("idle_reached", 32'(idle), 32'd1);
        @(posedge clk); #1;
        chk("done_cycles", 32'(done_cnt), 32'(exp_done));
        chk("err", 32'(err), 32'(exp_err));
        chk("err_code", 32'(err_code), 32'(exp_code));
        chk("in_ready_idle", 32'(in_ready), 32'd0);
        chk("pending_writes", 32'(exp_data_q.size()), 32'd0);
    endtask

    task automatic push_exp(input int addr, input logic [31:0] w);
        exp_addr_q.push_back(10'(addr));
        exp_data_q.push_back(w);
    endtask

    initial begin
        bit          acc;
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [25:0] imm;
        logic [31:0] r, w, w0;
        int          code, len, exp_err, exp_code;

        // Reset values
        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_wr_valid", 32'(wr_valid), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'({err, err_code}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single add
        do_start();
        chk("busy_after_start", 32'(busy), 1);
        issue(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 50, acc);
        chk("accept_add", 32'(acc), 1);
        push_exp(0, 32'h00221820);
        wait_idle_and_check(1, 0, 0);

        // lw with negative offset
        do_start();
        issue(4'd8, 5'd29, 5'd8, 5'd0, 26'h3FFFFFC, 1'b1, 50, acc);
        push_exp(0, 32'h8FA8FFFC);
        wait_idle_and_check(1, 0, 0);

        // Stalled write port: 4 accepted, 5th held off, outputs frozen
        rdy_mode = 1;
        @(posedge clk); #1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            issue(4'(i), 5'(i + 1), 5'(i + 7), 5'(i + 12), 26'h0, 1'b0, 50, acc);
            chk("accept_stall_fill", 32'(acc), 1);
            model(i, i + 1, i + 7, i + 12, 26'h0, i, w, code);
            if (i == 0) w0 = w;
            push_exp(i, w);
        end
        in_op = 4'd6; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd0; in_imm = 26'h3FF8000; in_last = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_wr_valid", 32'(wr_valid), 1);
            chk("stall_wr_addr", 32'(wr_addr), 0);
            chk("stall_wr_data", wr_data, w0);
        end
        @(posedge clk); #1;
        rdy_mode = 2;
        issue(4'd6, 5'd4, 5'd5, 5'd0, 26'h3FF8000, 1'b1, 50, acc);
        chk("accept_after_release", 32'(acc), 1);
        model(6, 4, 5, 0, 26'h3FF8000, 4, w, code);
        push_exp(4, w);
        wait_idle_and_check(1, 0, 0);

        // Illegal op after two good ones
        do_start();
        issue(4'd4, 5'd9, 5'd10, 5'd11, 26'h0, 1'b0, 50, acc);
        model(4, 9, 10, 11, 26'h0, 0, w, code);
        push_exp(0, w);
        issue(4'd9, 5'd2, 5'd3, 5'd0, 26'h0000040, 1'b0, 50, acc);
        model(9, 2, 3, 0, 26'h0000040, 1, w, code);
        push_exp(1, w);
        issue(4'hD, 5'd1, 5'd1, 5'd1, 26'h0, 1'b0, 50, acc);
        chk("accept_illegal", 32'(acc), 1);
        wait_idle_and_check(0, 1, 1);

        // Out-of-range immediate
        do_start();
        issue(4'd6, 5'd1, 5'd2, 5'd0, 26'h0010000, 1'b1, 50, acc);
        wait_idle_and_check(0, 1, 2);

`ifdef BRANCH_TARGET_CALC_EN
        // beq to absolute word 0 from address 2
        do_start();
        issue(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0, 50, acc);
        push_exp(0, 32'h00221820);
        issue(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0, 50, acc);
        push_exp(1, 32'h00221820);
        issue(4'd10, 5'd1, 5'd2, 5'd0, 26'h0, 1'b1, 50, acc);
        push_exp(2, 32'h1022FFFD);
        wait_idle_and_check(1, 0, 0);
`endif

        // Random programs under random backpressure
        rdy_mode = 0;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, 8);
            exp_err = 0;
            exp_code = 0;
            do_start();
            for (int i = 0; i < len; i++) begin
                op = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
                rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
                r = $urandom;
                if ($urandom_range(0, 7) == 0) imm = r[25:0];
                else if ($urandom_range(0, 3) == 0) imm = 26'($urandom_range(0, 12));
                else imm = {{10{r[15]}}, r[15:0]};
                model(int'(op), longint'(rs), longint'(rt), longint'(rd), imm, i, w, code);
                issue(op, rs, rt, rd, imm, (i == len - 1), 300, acc);
                chk("accept_rand", 32'(acc), 1);
                if (code != 0) begin
                    exp_err = 1;
                    exp_code = code;
                    break;
                end
                push_exp(i, w);
            end
            wait_idle_and_check(exp_err ? 0 : 1, exp_err, exp_code);
        end

        // Reset in the middle of a load
        rdy_mode = 1;
        @(posedge clk); #1;
        do_start();
        issue(4'd1, 5'd3, 5'd4, 5'd5, 26'h0, 1'b0, 50, acc);
        issue(4'd2, 5'd6, 5'd7, 5'd8, 26'h0, 1'b0, 50, acc);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_wr_valid", 32'(wr_valid), 0);
        chk("midrst_wr_addr", 32'(wr_addr), 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_err", 32'({err, err_code}), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_wr_valid", 32'(wr_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
